// File: rtl/c_add_sched.sv
// c_add_sched -- round-robin scheduler sharing one narrow c_add_nto1 adder.
//
// Grants one requester at a time, latches its num_ports operands, streams
// them to an external combinational adder `lanes` operands per cycle,
// accumulates the partial sums and returns the total tagged with the
// requester index.
//
// Optional build macro: C_ADD_SCHED_EARLY_DONE_EN
//   defined   -> ACCUM ends early once all remaining latched operands are
//                zero; an all-zero grant goes straight to DONE with sum 0.
//   undefined -> always exactly num_chunks ACCUM cycles, no zero detection.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   req_in           per-requester request level
//   data_in          operands; requester i at [i*num_ports*width +: num_ports*width]
//   gnt_out          one-hot grant (combinational); operands captured this cycle
//   add_operands_out operands driven to the external adder, lane 0 in low bits
//   add_sum_in       external adder result, same cycle
//   sum_valid_out    one-cycle result pulse
//   sum_out          completed sum, held until the next result
//   sum_id_out       requester index the sum belongs to
module c_add_sched #(
  parameter int num_requesters = 4,
  parameter int num_ports      = 4,
  parameter int width          = 8,
  parameter int lanes          = 2,
  localparam int num_chunks    = num_ports / lanes,
  localparam int out_width     = $clog2(num_ports) + width,
  localparam int add_width     = $clog2(lanes) + width,
  localparam int id_width      = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [num_requesters-1:0]             req_in,
  input  logic [num_requesters*num_ports*width-1:0] data_in,
  output logic [num_requesters-1:0]             gnt_out,
  output logic [lanes*width-1:0]                add_operands_out,
  input  logic [add_width-1:0]                  add_sum_in,
  output logic                                  sum_valid_out,
  output logic [out_width-1:0]                  sum_out,
  output logic [id_width-1:0]                   sum_id_out
);

  localparam int chunk_width = (num_chunks > 1) ? $clog2(num_chunks) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state, state_next;
  logic [id_width-1:0]         rr_ptr;
  logic [id_width-1:0]         gnt_idx;
  logic [id_width-1:0]         cand;
  logic                        gnt_found;
  logic                        grant;
  logic [num_ports*width-1:0]  gnt_ops;
  logic [num_ports*width-1:0]  ops_q;
  logic [id_width-1:0]         id_q;
  logic [out_width-1:0]        acc;
  logic [out_width-1:0]        acc_next;
  logic [chunk_width-1:0]      chunk;
  logic                        last_chunk;

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < num_requesters; k++) begin
      cand = id_width'((int'(rr_ptr) + k) % num_requesters);
      if (!gnt_found && req_in[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The grant window is open in IDLE and DONE so back-to-back requests
  // overlap the result cycle of the previous one.
  assign grant      = gnt_found && !reset && (state == IDLE || state == DONE);
  assign gnt_ops    = data_in[int'(gnt_idx)*(num_ports*width) +: num_ports*width];
  assign last_chunk = (chunk == chunk_width'(num_chunks - 1));
  assign acc_next   = acc + out_width'(add_sum_in);

`ifdef C_ADD_SCHED_EARLY_DONE_EN
  logic rest_zero;
  logic gnt_zero;

  // True when every latched chunk after the current one is all zero.
  always_comb begin
    rest_zero = 1'b1;
    for (int c = 0; c < num_chunks; c++) begin
      if (c > int'(chunk) && ops_q[c*(lanes*width) +: lanes*width] != '0)
        rest_zero = 1'b0;
    end
  end

  assign gnt_zero = (gnt_ops == '0);
`endif

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next       = state;
    gnt_out          = '0;
    add_operands_out = '0;

    if (grant)
      gnt_out = num_requesters'(1) << gnt_idx;

    if (state == ACCUM && !reset)
      add_operands_out = ops_q[int'(chunk)*(lanes*width) +: lanes*width];

    case (state)
      IDLE, DONE: begin
`ifdef C_ADD_SCHED_EARLY_DONE_EN
        if (grant) state_next = gnt_zero ? DONE : ACCUM;
        else       state_next = IDLE;
`else
        state_next = grant ? ACCUM : IDLE;
`endif
      end
      ACCUM: begin
`ifdef C_ADD_SCHED_EARLY_DONE_EN
        if (last_chunk || rest_zero) state_next = DONE;
`else
        if (last_chunk) state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      acc           <= '0;
      chunk         <= '0;
      sum_valid_out <= 1'b0;
      sum_out       <= '0;
      sum_id_out    <= '0;
    end else begin
      state         <= state_next;
      sum_valid_out <= (state_next == DONE);

      if (grant) begin
        acc    <= '0;
        chunk  <= '0;
        rr_ptr <= (gnt_idx == id_width'(num_requesters - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (state == ACCUM) begin
        acc   <= acc_next;
        chunk <= chunk + 1'b1;
      end

      // Result registers are loaded on entry to DONE and then hold. Entry
      // from a grant cycle only happens for an all-zero early-done request.
      if (state_next == DONE) begin
        sum_out    <= (state == ACCUM) ? acc_next : '0;
        sum_id_out <= (state == ACCUM) ? id_q : gnt_idx;
      end
    end
  end

  // NOTE: the operand/index latch is pure datapath, always written on a
  // grant before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      ops_q <= gnt_ops;
      id_q  <= gnt_idx;
    end
  end

endmodule
